// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared types and constants for the multiplier arbiter:
//                controller state encoding, default multiplier latency and
//                latency counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    // Width of the latency down-counter; holds MULT_CYCLES-1 for 1..255.
    localparam int CNT_W = 8;

    // Default latency of the external iterative multiplier.
    localparam int MULT_CYCLES_DEF = 4;

    // Controller state: waiting for a request, or a multiply in flight.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_arbiter_if
//  Description : Bundle of lane requests, multiplier handshake, hazard
//                stalls and architectural HI/LO between the execute stage
//                and the multiplier arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mult_arbiter_if #(
    parameter int WIDTH = 32
) ();

    // Lane side
    logic               req0;
    logic               req1;
    logic               sign0;
    logic               sign1;
    logic [WIDTH-1:0]   a0;
    logic [WIDTH-1:0]   b0;
    logic [WIDTH-1:0]   a1;
    logic [WIDTH-1:0]   b1;
    logic               rd_hilo0;
    logic               rd_hilo1;
    logic               kill;

    // Multiplier side
    logic               mult_start;
    logic               mult_sign;
    logic [WIDTH-1:0]   mult_a;
    logic [WIDTH-1:0]   mult_b;
    logic [2*WIDTH-1:0] mult_product;

    // Hazard / architectural state
    logic               stall0;
    logic               stall1;
    logic               busy;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;

    // Arbiter view
    modport slave (
        input  req0, req1, sign0, sign1, a0, b0, a1, b1,
        input  rd_hilo0, rd_hilo1, kill, mult_product,
        output mult_start, mult_sign, mult_a, mult_b,
        output stall0, stall1, busy, hi, lo
    );

    // Pipeline / multiplier view
    modport master (
        output req0, req1, sign0, sign1, a0, b0, a1, b1,
        output rd_hilo0, rd_hilo1, kill, mult_product,
        input  mult_start, mult_sign, mult_a, mult_b,
        input  stall0, stall1, busy, hi, lo
    );

endinterface : mult_arbiter_if
`default_nettype wire

// File: rtl/mult_latency_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : mult_latency_cnt
//  Description : Loadable down-counter tracking the remaining multiplier
//                latency. Clear beats load, load beats decrement; the count
//                saturates at zero. Zero flag is combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_latency_cnt
    import mult_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_W
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 load,
    input  wire logic                 enable,
    input  wire logic                 clear,
    input  wire logic [CNT_WIDTH-1:0] load_val,
    output      logic                 zero
);

    logic [CNT_WIDTH-1:0] r_cnt;

    // Counter register: synchronous active-low reset, then clear/load/decrement.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (enable && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule : mult_latency_cnt
`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mult_arbiter
//  Description : Shares one external iterative multiplier between two issue
//                lanes. Grants the older lane first, pulses the multiplier
//                start, counts its latency, captures the product into HI/LO
//                and stalls lanes that must wait for the multiplier or for
//                the new HI/LO value.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MULT_CYCLES_DEF
) (
    input  wire logic      clk,
    input  wire logic      reset,
    mult_arbiter_if.slave  bus
);

    // Counter preload: the first BUSY cycle already counts as one cycle.
    localparam logic [CNT_W-1:0] c_load_val = CNT_W'(MULT_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_cnt_load;
    logic               w_cnt_en;
    logic               w_cnt_clr;
    logic               w_cnt_zero;
    logic               w_capture;

    logic               w_mult_start;
    logic               w_mult_sign;
    logic [WIDTH-1:0]   w_mult_a;
    logic [WIDTH-1:0]   w_mult_b;
    logic               w_stall0;
    logic               w_stall1;
    logic               w_busy;

    // Latency counter: loaded on grant, runs down while BUSY.
    mult_latency_cnt #(
        .CNT_WIDTH (CNT_W)
    ) u_lat_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (w_cnt_load),
        .enable   (w_cnt_en),
        .clear    (w_cnt_clr),
        .load_val (c_load_val),
        .zero     (w_cnt_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Architectural HI/LO: cleared by reset, loaded only on a completed multiply.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_capture) begin
            r_hi <= bus.mult_product[2*WIDTH-1:WIDTH];
            r_lo <= bus.mult_product[WIDTH-1:0];
        end
    end

    // Grant, stall and next-state decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_mult_start = 1'b0;
        w_mult_sign  = bus.sign0;
        w_mult_a     = bus.a0;
        w_mult_b     = bus.b0;
        w_stall0     = 1'b0;
        w_stall1     = 1'b0;
        w_busy       = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_en     = 1'b0;
        w_cnt_clr    = 1'b0;
        w_capture    = 1'b0;

        if (!reset) begin
            // Every output is held low while reset is applied.
            w_state_nxt = IDLE;
            w_mult_sign = 1'b0;
            w_mult_a    = '0;
            w_mult_b    = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!bus.kill) begin
                        if (bus.req0) begin
                            // Lane 0 is older and wins. Lane 1 waits if it
                            // wants the multiplier or must read the new HI/LO.
                            w_mult_start = 1'b1;
                            w_stall1     = bus.req1 | bus.rd_hilo1;
                            w_cnt_load   = 1'b1;
                            w_state_nxt  = BUSY;
                        end else if (bus.req1) begin
                            // Lane 0 reading HI/LO sees the pre-multiply value.
                            w_mult_start = 1'b1;
                            w_mult_sign  = bus.sign1;
                            w_mult_a     = bus.a1;
                            w_mult_b     = bus.b1;
                            w_cnt_load   = 1'b1;
                            w_state_nxt  = BUSY;
                        end
                    end
                end

                BUSY: begin
                    w_busy   = 1'b1;
                    w_stall0 = bus.req0 | bus.rd_hilo0;
                    w_stall1 = bus.req1 | bus.rd_hilo1;
                    if (bus.kill) begin
                        // Flush discards the product, even on the final cycle.
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = IDLE;
                    end else if (w_cnt_zero) begin
                        w_capture   = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_en = 1'b1;
                    end
                end

                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign bus.mult_start = w_mult_start;
    assign bus.mult_sign  = w_mult_sign;
    assign bus.mult_a     = w_mult_a;
    assign bus.mult_b     = w_mult_b;
    assign bus.stall0     = w_stall0;
    assign bus.stall1     = w_stall1;
    assign bus.busy       = w_busy;
    assign bus.hi         = r_hi;
    assign bus.lo         = r_lo;

endmodule : mult_arbiter
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_arbiter
//  Description : Self-checking bench for mult_arbiter. A cycle-based model
//                tracks when a multiply was granted and what product it will
//                yield; the bench also plays the external multiplier, which
//                presents the true product only on its valid cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_arbiter;

    localparam int WIDTH = 32;
    localparam int MC    = 4;

    logic clk = 1'b0;
    logic reset;

    mult_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mult_arbiter #(
        .WIDTH       (WIDTH),
        .MULT_CYCLES (MC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

    // Model: in-flight flag, grant cycle, pending product, HI/LO.
    bit          m_busy  = 1'b0;
    int          m_start = 0;
    logic [63:0] m_prod  = '0;
    logic [31:0] m_hi    = '0;
    logic [31:0] m_lo    = '0;

    function automatic logic [63:0] mul(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s ? {{32{a[31]}}, a} : {32'b0, a};
        eb = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic idle_in();
        bus.req0 = 0; bus.req1 = 0; bus.rd_hilo0 = 0; bus.rd_hilo1 = 0; bus.kill = 0;
    endtask

    // Drive the multiplier result, then compare every DUT output to the model.
    task automatic cmp();
        logic        e_start, e_sign, e_s0, e_s1, e_busy;
        logic [31:0] e_a, e_b;
        if (m_busy && (cyc == m_start + MC))
            bus.mult_product = m_prod;
        else
            bus.mult_product = {$urandom(), $urandom()};
        #1;
        e_start = 0; e_sign = bus.sign0; e_a = bus.a0; e_b = bus.b0;
        e_s0 = 0; e_s1 = 0; e_busy = 0;
        if (!reset) begin
            e_sign = 0; e_a = '0; e_b = '0;
        end else if (!m_busy) begin
            if (!bus.kill) begin
                if (bus.req0) begin
                    e_start = 1;
                    e_s1    = bus.req1 | bus.rd_hilo1;
                end else if (bus.req1) begin
                    e_start = 1; e_sign = bus.sign1; e_a = bus.a1; e_b = bus.b1;
                end
            end
        end else begin
            e_busy = 1;
            e_s0   = bus.req0 | bus.rd_hilo0;
            e_s1   = bus.req1 | bus.rd_hilo1;
        end
        chk("mult_start", bus.mult_start, e_start);
        chk("mult_sign",  bus.mult_sign,  e_sign);
        chk("mult_a",     bus.mult_a,     e_a);
        chk("mult_b",     bus.mult_b,     e_b);
        chk("stall0",     bus.stall0,     e_s0);
        chk("stall1",     bus.stall1,     e_s1);
        chk("busy",       bus.busy,       e_busy);
        chk("hi",         bus.hi,         m_hi);
        chk("lo",         bus.lo,         m_lo);
    endtask

    // Advance the model with this cycle's inputs, then cross the clock edge.
    task automatic tick();
        if (!reset) begin
            m_busy = 0; m_hi = '0; m_lo = '0;
        end else if (!m_busy) begin
            if (!bus.kill && (bus.req0 || bus.req1)) begin
                m_busy  = 1;
                m_start = cyc;
                m_prod  = bus.req0 ? mul(bus.sign0, bus.a0, bus.b0)
                                   : mul(bus.sign1, bus.a1, bus.b1);
            end
        end else if (bus.kill) begin
            m_busy = 0;
        end else if (cyc == m_start + MC) begin
            {m_hi, m_lo} = m_prod;
            m_busy = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            cmp();
            tick();
        end
    endtask

    initial begin
        reset = 0;
        idle_in();
        bus.sign0 = 0; bus.sign1 = 0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        bus.mult_product = '0;
        tick();

        // Reset state, with a request present that must be ignored.
        bus.req0 = 1;
        cmp();
        chk("rst_start", bus.mult_start, 0);
        chk("rst_busy",  bus.busy, 0);
        chk("rst_lo",    bus.lo, 0);
        tick();
        reset = 1;
        idle_in();
        run(1);

        // 7*6 unsigned on lane 0.
        bus.req0 = 1; bus.a0 = 7; bus.b0 = 6; bus.sign0 = 0;
        cmp(); chk("t1_start", bus.mult_start, 1); tick();
        bus.req0 = 0;
        for (int i = 1; i <= MC; i++) begin
            cmp(); chk("t1_busy", bus.busy, 1); chk("t1_nostart", bus.mult_start, 0); tick();
        end
        cmp(); chk("t1_hi", bus.hi, 0); chk("t1_lo", bus.lo, 42); chk("t1_idle", bus.busy, 0); tick();

        // Both lanes request: lane 0 (2*3) first, lane 1 (-3*5 signed) next.
        bus.req0 = 1; bus.a0 = 2; bus.b0 = 3; bus.sign0 = 0;
        bus.req1 = 1; bus.a1 = 32'hFFFF_FFFD; bus.b1 = 5; bus.sign1 = 1;
        cmp(); chk("t2_start", bus.mult_start, 1); chk("t2_stall1", bus.stall1, 1); tick();
        bus.req0 = 0;
        for (int i = 0; i < MC; i++) begin
            cmp(); chk("t2_stall1_busy", bus.stall1, 1); tick();
        end
        cmp();
        chk("t2_grant1", bus.mult_start, 1);
        chk("t2_a1", bus.mult_a, 32'hFFFF_FFFD);
        chk("t2_nostall", bus.stall1, 0);
        chk("t2_lo0", bus.lo, 6);
        tick();
        bus.req1 = 0;
        run(MC);
        cmp(); chk("t2_hi", bus.hi, 32'hFFFF_FFFF); chk("t2_lo", bus.lo, 32'hFFFF_FFF1); tick();

        // req0 with rd_hilo1 held through BUSY.
        bus.req0 = 1; bus.a0 = 9; bus.b0 = 9; bus.sign0 = 1; bus.rd_hilo1 = 1;
        cmp(); chk("t3_stall1", bus.stall1, 1); tick();
        bus.req0 = 0;
        for (int i = 0; i < MC; i++) begin
            cmp(); chk("t3_stall1_busy", bus.stall1, 1); tick();
        end
        cmp(); chk("t3_release", bus.stall1, 0); chk("t3_lo", bus.lo, 81); tick();
        bus.rd_hilo1 = 0;

        // rd_hilo0 with req1: older lane does not stall.
        bus.req1 = 1; bus.a1 = 6; bus.b1 = 7; bus.sign1 = 0; bus.rd_hilo0 = 1;
        cmp(); chk("t4_stall0", bus.stall0, 0); chk("t4_start", bus.mult_start, 1); tick();
        idle_in();
        run(MC);
        cmp(); chk("t4_lo", bus.lo, 42); tick();

        // 2*3 killed on its final BUSY cycle.
        bus.req0 = 1; bus.a0 = 2; bus.b0 = 3; bus.sign0 = 0;
        cmp(); tick();
        bus.req0 = 0;
        run(MC - 1);
        bus.kill = 1;
        cmp(); chk("t5_busy", bus.busy, 1); tick();
        bus.kill = 0;
        cmp();
        chk("t5_hi", bus.hi, 0); chk("t5_lo", bus.lo, 42); chk("t5_idle", bus.busy, 0);
        chk("t5_s0", bus.stall0, 0); chk("t5_s1", bus.stall1, 0);
        tick();

        // Reset mid-BUSY with lane 0 requesting throughout.
        bus.req0 = 1; bus.a0 = 5; bus.b0 = 5; bus.sign0 = 0;
        run(2);
        reset = 0;
        cmp(); chk("t6_rst_start", bus.mult_start, 0); chk("t6_rst_busy", bus.busy, 0); tick();
        reset = 1;
        cmp();
        chk("t6_hi", bus.hi, 0); chk("t6_lo", bus.lo, 0);
        chk("t6_busy", bus.busy, 0); chk("t6_regrant", bus.mult_start, 1);
        tick();
        bus.req0 = 0;
        run(MC);
        cmp(); chk("t6_lo25", bus.lo, 25); tick();

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            reset        = ($urandom_range(0, 99) >= 2);
            bus.req0     = ($urandom_range(0, 99) < 30);
            bus.req1     = ($urandom_range(0, 99) < 30);
            bus.rd_hilo0 = ($urandom_range(0, 99) < 20);
            bus.rd_hilo1 = ($urandom_range(0, 99) < 20);
            bus.kill     = ($urandom_range(0, 99) < 4);
            bus.sign0    = 1'($urandom_range(0, 1));
            bus.sign1    = 1'($urandom_range(0, 1));
            bus.a0       = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 255));
            bus.b0       = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 255));
            bus.a1       = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 255));
            bus.b1       = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 255));
            cmp();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mult_arbiter
`default_nettype wire
